forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit_pkg.sv | 41 ++++
 rtl/forward_hazard_unit_hazard_slot.sv | 19 +
 rtl/forward_hazard_unit.sv | 63 ++++++
 tb/tb_forward_hazard_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit and the datapath operand muxes:
// mux select encodings, pipeline slot record and the forwarding priority function.
package forward_hazard_unit_pkg;

   localparam int DEF_REG_ADDR_W = 5;

   // Operand mux selects; 2'b11 is never produced.
   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;

   typedef struct packed {
      logic                      valid;
      logic [DEF_REG_ADDR_W-1:0] rs;
      logic [DEF_REG_ADDR_W-1:0] rt;
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic                      regwrite;
      logic                      memread;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '0;

   // True when a slot will write a nonzero register equal to src.
   function automatic logic produces(input slot_t s, input logic [DEF_REG_ADDR_W-1:0] src);
      return s.valid && s.regwrite && (s.rd != '0) && (s.rd == src);
   endfunction

   // Most recent producer wins: the MEM slot is checked before the WB slot.
   function automatic logic [1:0] fwd_sel(input logic ex_valid,
                                          input logic [DEF_REG_ADDR_W-1:0] src,
                                          input slot_t mem, input slot_t wb);
      logic [1:0] sel;
      sel = FWD_REGFILE;
      if (ex_valid) begin
         if (produces(mem, src))     sel = FWD_EXMEM;
         else if (produces(wb, src)) sel = FWD_MEMWB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/forward_hazard_unit_hazard_slot.sv
// One pipeline slot record; reset and bubble both clear it so no stale
// register numbers linger in an invalid slot.
module hazard_slot
   import forward_hazard_unit_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  bubble,
   input  slot_t d,
   output slot_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         q <= SLOT_BUBBLE;
      else if (bubble) q <= SLOT_BUBBLE;
      else             q <= d;
   end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding select and load-use stall detection for a classic 5-stage pipeline,
// tracking the instructions in EX, MEM and WB as three shadow slots.
module forward_hazard_unit
   import forward_hazard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_regwrite_i,
   input  logic                  id_memread_i,
   input  logic                  flush_i,
   output logic [1:0]            forward_a_o,
   output logic [1:0]            forward_b_o,
   output logic                  stall_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   slot_t id_slot, ex_q, mem_q, wb_q;
   logic  ex_bubble;
   logic  load_use;

   always_comb begin
      id_slot          = SLOT_BUBBLE;
      id_slot.valid    = id_valid_i;
      id_slot.rs       = id_rs_i;
      id_slot.rt       = id_rt_i;
      id_slot.rd       = id_rd_i;
      id_slot.regwrite = id_regwrite_i;
      id_slot.memread  = id_memread_i;
   end

   // A pending load in EX whose result the ID instruction needs; flush kills the consumer.
   assign load_use = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.rd != '0) &&
                     ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));
   assign stall_o  = id_valid_i && !flush_i && load_use;

   assign ex_bubble = stall_o || flush_i || !id_valid_i;

   hazard_slot u_ex  (.clk(clk_i), .rst(rst_i), .bubble(ex_bubble), .d(id_slot), .q(ex_q));
   hazard_slot u_mem (.clk(clk_i), .rst(rst_i), .bubble(1'b0),      .d(ex_q),    .q(mem_q));
   hazard_slot u_wb  (.clk(clk_i), .rst(rst_i), .bubble(1'b0),      .d(mem_q),   .q(wb_q));

   assign forward_a_o = fwd_sel(ex_q.valid, ex_q.rs, mem_q, wb_q);
   assign forward_b_o = fwd_sel(ex_q.valid, ex_q.rt, mem_q, wb_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         stall_cnt_o <= '0;
      else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
   end

   // Source fields of the older slots only matter in EX; memread only matters in EX.
   logic unused_slot_bits;
   assign unused_slot_bits = ^{mem_q.rt, mem_q.memread, wb_q.rs, wb_q.rt, wb_q.memread, ex_q.rt[0] & 1'b0};

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding paths, load-use stall,
// flush priority, r0 handling, counter saturation and asynchronous reset.
module tb_forward_hazard_unit;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       id_valid_i;
   logic [4:0] id_rs_i, id_rt_i, id_rd_i;
   logic       id_regwrite_i, id_memread_i, flush_i;
   logic [1:0] forward_a_o, forward_b_o;
   logic       stall_o;
   logic [3:0] stall_cnt_o;

   int total = 0;
   int bad   = 0;

   forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
      .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
      .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic set_id(input logic v, input int rs, input int rt, input int rd,
                         input logic rw, input logic mr);
      id_valid_i    = v;
      id_rs_i       = 5'(rs);
      id_rt_i       = 5'(rt);
      id_rd_i       = 5'(rd);
      id_regwrite_i = rw;
      id_memread_i  = mr;
      #1;
   endtask

   task automatic nop();
      set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      nop();
      repeat (3) step();
   endtask

   task automatic test_reset();
      flush_i = 1'b0;
      set_id(1'b1, 3, 3, 3, 1'b1, 1'b1);
      rst_i = 1'b1;
      repeat (2) step();
      total++;
      if ({forward_a_o, forward_b_o, stall_o, stall_cnt_o} !== 9'b0) begin
         bad++;
         $display("FAIL reset_outputs: got a=%b b=%b stall=%b cnt=%0d, want 00 00 0 0",
                  forward_a_o, forward_b_o, stall_o, stall_cnt_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      drain();
   endtask

   // add r3=r1+r2 ; sub r7=r3-r4
   task automatic test_ex_mem_fwd();
      set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);
      step();
      set_id(1'b1, 3, 4, 7, 1'b1, 1'b0);
      step();
      total++;
      if (forward_a_o !== 2'b10 || forward_b_o !== 2'b00) begin
         bad++;
         $display("FAIL ex_mem_fwd: got a=%b b=%b, want a=10 b=00", forward_a_o, forward_b_o);
      end
      drain();
   endtask

   // add r3 ; nop ; or r4=r3|r3
   task automatic test_mem_wb_fwd();
      set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);
      step();
      nop();
      step();
      set_id(1'b1, 3, 3, 4, 1'b1, 1'b0);
      step();
      total++;
      if (forward_a_o !== 2'b01 || forward_b_o !== 2'b01) begin
         bad++;
         $display("FAIL mem_wb_fwd: got a=%b b=%b, want a=01 b=01", forward_a_o, forward_b_o);
      end
      drain();
   endtask

   // lw r5,0(r2) ; add r6=r5+r1
   task automatic test_load_use();
      set_id(1'b1, 2, 0, 5, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5, 1, 6, 1'b1, 1'b0);
      total++;
      if (stall_o !== 1'b1 || stall_cnt_o !== 4'd0) begin
         bad++;
         $display("FAIL load_use_stall: got stall=%b cnt=%0d, want 1 0", stall_o, stall_cnt_o);
      end
      step();
      total++;
      if (stall_o !== 1'b0 || stall_cnt_o !== 4'd1) begin
         bad++;
         $display("FAIL load_use_release: got stall=%b cnt=%0d, want 0 1", stall_o, stall_cnt_o);
      end
      step();
      total++;
      if (forward_a_o !== 2'b01 || forward_b_o !== 2'b00 || stall_o !== 1'b0) begin
         bad++;
         $display("FAIL load_use_fwd: got a=%b b=%b stall=%b, want 01 00 0",
                  forward_a_o, forward_b_o, stall_o);
      end
      drain();
   endtask

   // add r3 ; add r3 ; reader of r3 -> newest (MEM) wins
   task automatic test_priority();
      set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);
      step();
      set_id(1'b1, 4, 5, 3, 1'b1, 1'b0);
      step();
      set_id(1'b1, 3, 9, 8, 1'b1, 1'b0);
      step();
      total++;
      if (forward_a_o !== 2'b10 || forward_b_o !== 2'b00) begin
         bad++;
         $display("FAIL mem_over_wb: got a=%b b=%b, want a=10 b=00", forward_a_o, forward_b_o);
      end
      drain();
   endtask

   task automatic test_r0_and_flush();
      set_id(1'b1, 1, 2, 0, 1'b1, 1'b0);
      step();
      set_id(1'b1, 0, 0, 7, 1'b1, 1'b0);
      step();
      total++;
      if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00) begin
         bad++;
         $display("FAIL r0_no_fwd: got a=%b b=%b, want 00 00", forward_a_o, forward_b_o);
      end
      drain();
      // lw r5 in EX, consumer of r5 in ID while a branch flushes it
      set_id(1'b1, 2, 0, 5, 1'b1, 1'b1);
      step();
      flush_i = 1'b1;
      set_id(1'b1, 5, 1, 6, 1'b1, 1'b0);
      total++;
      if (stall_o !== 1'b0) begin
         bad++;
         $display("FAIL flush_kills_stall: got stall=%b, want 0", stall_o);
      end
      step();
      flush_i = 1'b0;
      nop();
      // A non-bubbled consumer of r5 in EX would see the load in MEM and select 10.
      total++;
      if (forward_a_o !== 2'b00 || stall_cnt_o !== 4'd1) begin
         bad++;
         $display("FAIL flush_bubble: got a=%b cnt=%0d, want 00 1", forward_a_o, stall_cnt_o);
      end
      drain();
   endtask

   // Counter width is 4 here: 20 more stalls from 1 must stop at 15.
   task automatic test_saturation();
      for (int i = 1; i <= 20; i++) begin
         set_id(1'b1, 2, 0, 5, 1'b1, 1'b1);
         step();
         set_id(1'b1, 5, 1, 6, 1'b1, 1'b0);
         step();
         step();
         if (i == 13) begin
            total++;
            if (stall_cnt_o !== 4'd14) begin
               bad++;
               $display("FAIL cnt_before_sat: got %0d, want 14", stall_cnt_o);
            end
         end
      end
      total++;
      if (stall_cnt_o !== 4'd15) begin
         bad++;
         $display("FAIL cnt_saturate: got %0d, want 15", stall_cnt_o);
      end
      drain();
   endtask

   task automatic test_mid_reset();
      set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);
      step();
      set_id(1'b1, 3, 3, 4, 1'b1, 1'b0);
      step();
      total++;
      if (forward_a_o !== 2'b10 || forward_b_o !== 2'b10) begin
         bad++;
         $display("FAIL pre_reset_fwd: got a=%b b=%b, want 10 10", forward_a_o, forward_b_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      total++;
      if ({forward_a_o, forward_b_o, stall_o, stall_cnt_o} !== 9'b0) begin
         bad++;
         $display("FAIL async_reset: got a=%b b=%b stall=%b cnt=%0d, want 00 00 0 0",
                  forward_a_o, forward_b_o, stall_o, stall_cnt_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      step();
      total++;
      if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00) begin
         bad++;
         $display("FAIL post_reset_no_fwd: got a=%b b=%b, want 00 00", forward_a_o, forward_b_o);
      end
      step();
      total++;
      if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00 || stall_cnt_o !== 4'd0) begin
         bad++;
         $display("FAIL post_reset_steady: got a=%b b=%b cnt=%0d, want 00 00 0",
                  forward_a_o, forward_b_o, stall_cnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_ex_mem_fwd();
      test_mem_wb_fwd();
      test_load_use();
      test_priority();
      test_r0_and_flush();
      test_saturation();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
